// File: rtl/motor_pwm_generator.sv
// Four-channel ESC/servo PWM generator clocked from the 1 MHz microsecond tick.
// Rate commands are saturated, scaled to a 1000-2000 us pulse and latched once per period.
module motor_pwm_generator #(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int PERIOD_US       = 20000,
   parameter int MIN_PULSE_US    = 1000,
   parameter int US_PER_STEP     = 4,
   parameter int MAX_RATE        = 250
) (
   input  logic                       us_clk,
   input  logic                       resetn,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_1_rate,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_2_rate,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_3_rate,
   input  logic [INPUT_BIT_WIDTH-1:0] motor_4_rate,
   output logic                       motor_1_pwm,
   output logic                       motor_2_pwm,
   output logic                       motor_3_pwm,
   output logic                       motor_4_pwm
);

   localparam int CNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
   localparam int WID_W = 16;

   logic [CNT_W-1:0]           cnt_r;
   logic [WID_W-1:0]           w_r     [4];
   logic [WID_W-1:0]           w_new_s [4];
   logic [INPUT_BIT_WIDTH-1:0] rate_s  [4];
   logic [3:0]                 pwm_r;
   logic                       cnt_zero_s;
   logic                       cnt_last_s;

   // Saturate the command at MAX_RATE, then scale to a pulse width in microseconds.
   function automatic logic [WID_W-1:0] pulse_width(input logic [INPUT_BIT_WIDTH-1:0] rate);
      logic [WID_W-1:0] r;
      if (WID_W'(rate) > WID_W'(MAX_RATE)) begin
         r = WID_W'(MAX_RATE);
      end else begin
         r = WID_W'(rate);
      end
      return WID_W'(MIN_PULSE_US) + (r * WID_W'(US_PER_STEP));
   endfunction

   assign rate_s[0] = motor_1_rate;
   assign rate_s[1] = motor_2_rate;
   assign rate_s[2] = motor_3_rate;
   assign rate_s[3] = motor_4_rate;

   assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
   assign cnt_last_s = (cnt_r == CNT_W'(PERIOD_US - 1));

   // Candidate widths computed every cycle; only consumed at the period start.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_new_s[i] = pulse_width(rate_s[i]);
      end
   end

   // Shared period counter: 0 .. PERIOD_US-1, then wrap.
   always_ff @(posedge us_clk) begin
      if (resetn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_last_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Width latch at period start and registered PWM compare.
   always_ff @(posedge us_clk) begin
      if (resetn) begin
         for (int i = 0; i < 4; i++) begin
            w_r[i] <= {WID_W{1'b0}};
         end
         pwm_r <= 4'b0000;
      end else if (cnt_zero_s) begin
         // The new width, not the stale one, decides the first high cycle.
         for (int i = 0; i < 4; i++) begin
            w_r[i]   <= w_new_s[i];
            pwm_r[i] <= (w_new_s[i] > {WID_W{1'b0}});
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            pwm_r[i] <= (WID_W'(cnt_r) < w_r[i]);
         end
      end
   end

   assign motor_1_pwm = pwm_r[0];
   assign motor_2_pwm = pwm_r[1];
   assign motor_3_pwm = pwm_r[2];
   assign motor_4_pwm = pwm_r[3];

endmodule

// File: tb/tb_motor_pwm_generator.sv
// Self-checking bench for motor_pwm_generator: measures whole PWM periods and
// compares high times and edge alignment against widths computed from the rate rules.
module tb_motor_pwm_generator;

   localparam int P = 2500;

   typedef int  int4_t [4];
   typedef bit  bit4_t [4];

   logic       us_clk = 1'b0;
   logic       resetn;
   logic [7:0] rate [4];
   logic [3:0] pwm;

   int checks = 0;
   int passes = 0;

   motor_pwm_generator #(
      .INPUT_BIT_WIDTH(8),
      .PERIOD_US      (P),
      .MIN_PULSE_US   (1000),
      .US_PER_STEP    (4),
      .MAX_RATE       (250)
   ) dut (
      .us_clk      (us_clk),
      .resetn      (resetn),
      .motor_1_rate(rate[0]),
      .motor_2_rate(rate[1]),
      .motor_3_rate(rate[2]),
      .motor_4_rate(rate[3]),
      .motor_1_pwm (pwm[0]),
      .motor_2_pwm (pwm[1]),
      .motor_3_pwm (pwm[2]),
      .motor_4_pwm (pwm[3])
   );

   always #5 us_clk = ~us_clk;

   // Reference: 1000 us plus 4 us per step, saturating at rate 250.
   function automatic int ref_width(input int r);
      return (r > 250) ? 2000 : 1000 + 4 * r;
   endfunction

   // Observe one full period starting at its first edge. ok[ch] is set when the
   // channel is high on the first sample and its high samples form one leading run.
   // Optionally changes one rate input mid-period after sample chg_at.
   task automatic measure(input int chg_at, input int chg_ch, input logic [7:0] chg_val,
                          output int4_t hi, output bit4_t ok);
      bit low_seen [4];
      for (int c = 0; c < 4; c++) begin
         hi[c] = 0; ok[c] = 1'b1; low_seen[c] = 1'b0;
      end
      for (int s = 0; s < P; s++) begin
         @(negedge us_clk);
         for (int c = 0; c < 4; c++) begin
            if (pwm[c] === 1'b1) begin
               hi[c]++;
               if (low_seen[c]) ok[c] = 1'b0;
            end else begin
               low_seen[c] = 1'b1;
               if (s == 0) ok[c] = 1'b0;
            end
         end
         if (s == chg_at) rate[chg_ch] = chg_val;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      for (int c = 0; c < 4; c++) rate[c] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
         @(negedge us_clk);
         checks++;
         if (pwm !== 4'b0000) $display("FAIL reset_hold cyc%0d: got %b expected 0000", k, pwm);
         else passes++;
      end
   endtask

   task automatic test_basic();
      int4_t hi; bit4_t ok; int exp [4];
      rate[0] = 8'd30; rate[1] = 8'd0; rate[2] = 8'd0; rate[3] = 8'd0;
      resetn = 1'b0;
      for (int c = 0; c < 4; c++) exp[c] = ref_width(int'(rate[c]));
      for (int p = 0; p < 4; p++) begin
         measure(-1, 0, 8'd0, hi, ok);
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (hi[c] !== exp[c]) $display("FAIL basic_width p%0d ch%0d: got %0d expected %0d", p, c, hi[c], exp[c]);
            else passes++;
            checks++;
            if (ok[c] !== 1'b1) $display("FAIL basic_align p%0d ch%0d: got %0d expected 1", p, c, ok[c]);
            else passes++;
         end
      end
   endtask

   task automatic test_mid_change();
      int4_t hi; bit4_t ok;
      measure(100, 1, 8'd85, hi, ok);
      checks++;
      if (hi[1] !== 1000) $display("FAIL mid_change_current: got %0d expected 1000", hi[1]);
      else passes++;
      measure(-1, 0, 8'd0, hi, ok);
      checks++;
      if (hi[1] !== 1340) $display("FAIL mid_change_next: got %0d expected 1340", hi[1]);
      else passes++;
      checks++;
      if (ok[1] !== 1'b1) $display("FAIL mid_change_align: got %0d expected 1", ok[1]);
      else passes++;
   endtask

   task automatic test_saturation();
      int4_t hi; bit4_t ok;
      rate[2] = 8'd255; rate[3] = 8'd250;
      measure(-1, 0, 8'd0, hi, ok);
      checks++;
      if (hi[2] !== 2000) $display("FAIL sat_255: got %0d expected 2000", hi[2]);
      else passes++;
      checks++;
      if (hi[3] !== 2000) $display("FAIL sat_250: got %0d expected 2000", hi[3]);
      else passes++;
      rate[0] = 8'd251;
      measure(-1, 0, 8'd0, hi, ok);
      checks++;
      if (hi[0] !== 2000) $display("FAIL sat_251: got %0d expected 2000", hi[0]);
      else passes++;
   endtask

   task automatic test_independence();
      int4_t hi; bit4_t ok;
      int exp [4] = '{1000, 1248, 1500, 2000};
      rate[0] = 8'd0; rate[1] = 8'd62; rate[2] = 8'd125; rate[3] = 8'd250;
      measure(-1, 0, 8'd0, hi, ok);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (hi[c] !== exp[c] || ok[c] !== 1'b1)
            $display("FAIL indep ch%0d: got %0d/%0d expected %0d/1", c, hi[c], ok[c], exp[c]);
         else passes++;
      end
   endtask

   task automatic test_random();
      int4_t hi; bit4_t ok; int exp [4];
      for (int p = 0; p < 6; p++) begin
         for (int c = 0; c < 4; c++) begin
            rate[c] = 8'($urandom_range(0, 255));
            exp[c]  = ref_width(int'(rate[c]));
         end
         measure($urandom_range(1, P - 2), $urandom_range(0, 3), 8'($urandom_range(0, 255)), hi, ok);
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (hi[c] !== exp[c] || ok[c] !== 1'b1)
               $display("FAIL random p%0d ch%0d rate%0d: got %0d/%0d expected %0d/1", p, c, rate[c], hi[c], ok[c], exp[c]);
            else passes++;
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      int4_t hi; bit4_t ok; int exp [4];
      for (int c = 0; c < 4; c++) rate[c] = 8'($urandom_range(0, 255));
      for (int s = 0; s < 500; s++) @(negedge us_clk);
      checks++;
      if (pwm !== 4'b1111) $display("FAIL pre_reset_high: got %b expected 1111", pwm);
      else passes++;
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge us_clk);
         checks++;
         if (pwm !== 4'b0000) $display("FAIL reset_mid cyc%0d: got %b expected 0000", k, pwm);
         else passes++;
      end
      for (int c = 0; c < 4; c++) begin
         rate[c] = 8'($urandom_range(0, 255));
         exp[c]  = ref_width(int'(rate[c]));
      end
      resetn = 1'b0;
      measure(-1, 0, 8'd0, hi, ok);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (hi[c] !== exp[c] || ok[c] !== 1'b1)
            $display("FAIL restart ch%0d: got %0d/%0d expected %0d/1", c, hi[c], ok[c], exp[c]);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mid_change();
      test_saturation();
      test_independence();
      test_random();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
